// File: rtl/gate_chk_pkg.sv
// Shared encodings for the Ch1 gate sweep checker: FSM states, gate bit positions
// inside the five-bit gate output word, and the sizes of the gate and vector sets.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam int GATE_N = 5;
   localparam int VEC_N  = 4;

   localparam int G_NOT  = 0;
   localparam int G_NAND = 1;
   localparam int G_AND  = 2;
   localparam int G_OR   = 3;
   localparam int G_XOR  = 4;

endpackage

// File: rtl/gate_golden.sv
// Golden truth table for the Ch1 gate set; in_vec bit0 = a, bit1 = b.
// Purely combinational so other Ch1 benches can reuse it directly.
module gate_golden
   import gate_chk_pkg::*;
(
   input  logic [1:0]        in_vec_i,
   output logic [GATE_N-1:0] expected_o
);

   logic a;
   logic b;

   assign a = in_vec_i[0];
   assign b = in_vec_i[1];

   always_comb begin
      expected_o         = '0;
      expected_o[G_NOT]  = ~a;
      expected_o[G_NAND] = ~(a & b);
      expected_o[G_AND]  = a & b;
      expected_o[G_OR]   = a | b;
      expected_o[G_XOR]  = a ^ b;
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Clocked, restartable sweep of the two shared gate inputs with response checking
// against the golden table; reports pass, saturating error count and first failure.
module gate_sweep_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int LOOPS      = 1,
   parameter int CNT_W      = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic [1:0]        in_vec_o,
   input  logic [GATE_N-1:0] gate_out_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [CNT_W-1:0]  err_count_o,
   output logic [GATE_N-1:0] fail_mask_o,
   output logic [1:0]        first_fail_vec_o,
   output logic [GATE_N-1:0] first_fail_mask_o
);

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
   localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e            state_q;
   logic [1:0]        in_vec_q;
   logic [3:0]        settle_q;
   logic [7:0]        loop_q;
   logic [CNT_W-1:0]  err_q;
   logic [GATE_N-1:0] fail_mask_q;
   logic [1:0]        ffv_q;
   logic [GATE_N-1:0] ffm_q;
   logic              pass_q;
   logic              done_q;

   logic [GATE_N-1:0] golden;
   logic [GATE_N-1:0] mismatch_d;
   logic [CNT_W-1:0]  err_d;
   logic              last_d;

   gate_golden u_golden (
      .in_vec_i   (in_vec_q),
      .expected_o (golden)
   );

   assign mismatch_d = gate_out_i ^ golden;
   assign err_d      = sat_inc(err_q);
   assign last_d     = (in_vec_q == 2'd3) && (loop_q == LOOP_LAST);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         in_vec_q    <= '0;
         settle_q    <= '0;
         loop_q      <= '0;
         err_q       <= '0;
         fail_mask_q <= '0;
         ffv_q       <= '0;
         ffm_q       <= '0;
         pass_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_q     <= SETTLE;
                  in_vec_q    <= '0;
                  settle_q    <= SETTLE_LD;
                  loop_q      <= '0;
                  err_q       <= '0;
                  fail_mask_q <= '0;
                  ffv_q       <= '0;
                  ffm_q       <= '0;
                  pass_q      <= 1'b0;
                  done_q      <= 1'b0;
               end
            end
            SETTLE: begin
               if (settle_q == '0) begin
                  state_q <= CHECK;
               end else begin
                  settle_q <= settle_q - 4'd1;
               end
            end
            CHECK: begin
               // An empty fail_mask means nothing has failed yet in this run.
               if (mismatch_d != '0) begin
                  err_q <= err_d;
                  if (fail_mask_q == '0) begin
                     ffv_q <= in_vec_q;
                     ffm_q <= mismatch_d;
                  end
               end
               fail_mask_q <= fail_mask_q | mismatch_d;
               if (last_d) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  pass_q  <= (err_q == '0) && (mismatch_d == '0);
               end else begin
                  in_vec_q <= in_vec_q + 2'd1;
                  if (in_vec_q == 2'd3) begin
                     loop_q <= loop_q + 8'd1;
                  end
                  settle_q <= SETTLE_LD;
                  state_q  <= SETTLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_vec_o          = in_vec_q;
   assign busy_o            = (state_q == SETTLE) || (state_q == CHECK);
   assign done_o            = done_q;
   assign pass_o            = pass_q;
   assign err_count_o       = err_q;
   assign fail_mask_o       = fail_mask_q;
   assign first_fail_vec_o  = ffv_q;
   assign first_fail_mask_o = ffm_q;

endmodule
